// File: rtl/llc_bus_if.sv
// llc_bus_if: in-order request queue feeding a single-outstanding system-bus sequencer for the LLC.
// Optional build macro LLC_BUS_STATS_EN adds saturating stat_txn / stat_hitm / stat_beats counters.
module llc_bus_if #(
  parameter int ADDR_BITS    = 32,
  parameter int DEPTH        = 4,
  parameter int BEATS        = 8,
  parameter int SNOOP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [ADDR_BITS-1:0] req_addr,
  output logic                 rsp_valid,
  output logic [1:0]           rsp_op,
  output logic [ADDR_BITS-1:0] rsp_addr,
  output logic [1:0]           rsp_snoop,
  output logic                 bus_req,
  input  logic                 bus_gnt,
  output logic                 bus_addr_valid,
  output logic [ADDR_BITS-1:0] bus_addr,
  output logic [1:0]           bus_op,
  input  logic                 bus_hit,
  input  logic                 bus_hitm,
  input  logic                 bus_beat_ack,
  output logic                 bus_busy
`ifdef LLC_BUS_STATS_EN
  ,output logic [31:0]         stat_txn
  ,output logic [31:0]         stat_hitm
  ,output logic [31:0]         stat_beats
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SNP_W  = (SNOOP_CYCLES > 1) ? $clog2(SNOOP_CYCLES) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [1:0]       OP_INV    = 2'd2;
  localparam logic [1:0]       SNP_HIT   = 2'd0;
  localparam logic [1:0]       SNP_HITM  = 2'd1;
  localparam logic [1:0]       SNP_NOHIT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARB   = 3'd1,
    S_ADDR  = 3'd2,
    S_SNOOP = 3'd3,
    S_DATA  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // HITM dominates HIT when both agents respond.
  function automatic logic [1:0] snoop_code(input logic hit, input logic hitm);
    if (hitm) begin
      return SNP_HITM;
    end else if (hit) begin
      return SNP_HIT;
    end else begin
      return SNP_NOHIT;
    end
  endfunction

  logic [1:0]           q_op   [DEPTH];
  logic [ADDR_BITS-1:0] q_addr [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_next;
  logic                 push;
  logic                 pop;

  state_e               state;
  state_e               state_next;
  logic [1:0]           work_op;
  logic [ADDR_BITS-1:0] work_addr;
  logic [SNP_W-1:0]     snoop_cnt;
  logic [BEAT_W-1:0]    beat_cnt;
  logic [1:0]           snoop_r;
  logic [1:0]           snoop_now;
  logic [1:0]           snoop_final;
  logic                 snp_last;
  logic                 beat_last;

  // Queue occupancy; the head stays resident until its transaction reaches DONE.
  always_comb begin
    push       = req_valid && req_ready;
    pop        = (state == S_DONE);
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Request queue storage, pointers and registered ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= {PTR_W{1'b0}};
      rd_ptr    <= {PTR_W{1'b0}};
      count     <= {CNT_W{1'b0}};
      req_ready <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        q_op[i]   <= 2'd0;
        q_addr[i] <= {ADDR_BITS{1'b0}};
      end
    end else begin
      if (push) begin
        q_op[wr_ptr]   <= req_op;
        q_addr[wr_ptr] <= req_addr;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count     <= count_next;
      req_ready <= (count_next != CNT_FULL);
    end
  end

  // Next-state logic for the bus transaction sequencer.
  always_comb begin
    snp_last    = (snoop_cnt == SNP_W'(SNOOP_CYCLES - 1));
    beat_last   = (beat_cnt == BEAT_W'(BEATS - 1));
    snoop_now   = snoop_code(bus_hit, bus_hitm);
    snoop_final = (state == S_SNOOP) ? snoop_now : snoop_r;
    state_next  = state;
    case (state)
      S_IDLE: begin
        if (count != {CNT_W{1'b0}}) state_next = S_ARB;
        else                        state_next = S_IDLE;
      end
      S_ARB: begin
        if (bus_gnt) state_next = S_ADDR;
        else         state_next = S_ARB;
      end
      S_ADDR: state_next = S_SNOOP;
      S_SNOOP: begin
        if (snp_last) state_next = (work_op == OP_INV) ? S_DONE : S_DATA;
        else          state_next = S_SNOOP;
      end
      S_DATA: begin
        if (bus_beat_ack && beat_last) state_next = S_DONE;
        else                           state_next = S_DATA;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register, working entry, snoop/beat counters and the sampled snoop result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      work_op   <= 2'd0;
      work_addr <= {ADDR_BITS{1'b0}};
      snoop_cnt <= {SNP_W{1'b0}};
      beat_cnt  <= {BEAT_W{1'b0}};
      snoop_r   <= SNP_HIT;
    end else begin
      state <= state_next;
      if (state == S_IDLE && count != {CNT_W{1'b0}}) begin
        work_op   <= q_op[rd_ptr];
        work_addr <= q_addr[rd_ptr];
      end
      if (state == S_SNOOP) snoop_cnt <= snoop_cnt + SNP_W'(1);
      else                  snoop_cnt <= {SNP_W{1'b0}};
      if (state != S_DATA)   beat_cnt <= {BEAT_W{1'b0}};
      else if (bus_beat_ack) beat_cnt <= beat_cnt + BEAT_W'(1);
      if (state == S_SNOOP && snp_last) snoop_r <= snoop_now;
    end
  end

  // Outputs are registered from the next state so each one is valid for the whole state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_req        <= 1'b0;
      bus_addr_valid <= 1'b0;
      bus_addr       <= {ADDR_BITS{1'b0}};
      bus_op         <= 2'd0;
      bus_busy       <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_op         <= 2'd0;
      rsp_addr       <= {ADDR_BITS{1'b0}};
      rsp_snoop      <= 2'd0;
    end else begin
      bus_req        <= (state_next == S_ARB) || (state_next == S_ADDR) ||
                        (state_next == S_SNOOP) || (state_next == S_DATA);
      bus_busy       <= (state_next == S_ADDR) || (state_next == S_SNOOP) ||
                        (state_next == S_DATA);
      bus_addr_valid <= (state_next == S_ADDR);
      bus_addr       <= (state_next == S_ADDR) ? work_addr : {ADDR_BITS{1'b0}};
      bus_op         <= (state_next == S_ADDR) ? work_op : 2'd0;
      rsp_valid      <= (state_next == S_DONE);
      if (state_next == S_DONE) begin
        rsp_op    <= work_op;
        rsp_addr  <= work_addr;
        rsp_snoop <= snoop_final;
      end
    end
  end

`ifdef LLC_BUS_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_txn   <= 32'd0;
      stat_hitm  <= 32'd0;
      stat_beats <= 32'd0;
    end else begin
      if (state == S_DONE && stat_txn != 32'hFFFF_FFFF) stat_txn <= stat_txn + 32'd1;
      if (state == S_SNOOP && snp_last && snoop_now == SNP_HITM &&
          stat_hitm != 32'hFFFF_FFFF) stat_hitm <= stat_hitm + 32'd1;
      if (state == S_DATA && bus_beat_ack && stat_beats != 32'hFFFF_FFFF)
        stat_beats <= stat_beats + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_llc_bus_if.sv
// Self-checking bench for llc_bus_if: directed vector table, hand-written corner sequences
// and randomized single transactions checked against rule-level expectations.
module tb_llc_bus_if;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n, req_valid, req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic [1:0]    rsp_op;
  logic [AW-1:0] rsp_addr;
  logic [1:0]    rsp_snoop;
  logic          bus_req, bus_gnt, bus_addr_valid;
  logic [AW-1:0] bus_addr;
  logic [1:0]    bus_op;
  logic          bus_hit, bus_hitm, bus_beat_ack, bus_busy;
`ifdef LLC_BUS_STATS_EN
  logic [31:0]   stat_txn, stat_hitm, stat_beats;
`endif

  always #5 clk = ~clk;

  llc_bus_if #(.ADDR_BITS(AW), .DEPTH(4), .BEATS(8), .SNOOP_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_op(rsp_op), .rsp_addr(rsp_addr), .rsp_snoop(rsp_snoop),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_addr_valid(bus_addr_valid),
    .bus_addr(bus_addr), .bus_op(bus_op), .bus_hit(bus_hit), .bus_hitm(bus_hitm),
    .bus_beat_ack(bus_beat_ack), .bus_busy(bus_busy)
`ifdef LLC_BUS_STATS_EN
    , .stat_txn(stat_txn), .stat_hitm(stat_hitm), .stat_beats(stat_beats)
`endif
  );

  typedef struct { logic [1:0] op; logic [AW-1:0] addr; logic [1:0] snoop; int cyc; } rsp_t;
  typedef struct { logic [1:0] op; logic [AW-1:0] addr; logic hit; logic hitm;
                   logic [1:0] snoop; int lat; int busy; } vec_t;

  rsp_t          rsp_log[$];
  int            cyc = 0;
  int            av_total = 0;
  int            av_cyc = -100;
  int            busy_total = 0;
  logic [AW-1:0] av_addr = '0;
  logic [1:0]    av_op = 2'd0;
  int            n_tests = 0;
  int            n_fail = 0;
  int            ack_mode = 0;
  bit            gnt_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus/response monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rsp_valid) rsp_log.push_back('{op: rsp_op, addr: rsp_addr, snoop: rsp_snoop, cyc: cyc});
    if (bus_addr_valid) begin
      av_total <= av_total + 1;
      av_cyc   <= cyc;
      av_addr  <= bus_addr;
      av_op    <= bus_op;
    end
    if (bus_busy) busy_total <= busy_total + 1;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] model_snoop(input logic hit, input logic hitm);
    return hitm ? 2'd1 : (hit ? 2'd0 : 2'd2);
  endfunction

  // Advance one clock, then drive ack/grant for the new cycle.
  task automatic step();
    int j;
    @(posedge clk);
    #1;
    case (ack_mode)
      0: bus_beat_ack = 1'b1;
      1: begin
        j = cyc - av_cyc - 3;
        bus_beat_ack = (j >= 0) && (j % 3 == 2);
      end
      2: bus_beat_ack = 1'($urandom_range(0, 1));
      default: bus_beat_ack = 1'b0;
    endcase
    if (gnt_rand) bus_gnt = 1'($urandom_range(0, 1));
  endtask

  task automatic push(input logic [1:0] op, input logic [AW-1:0] addr, output int pc);
    int guard = 0;
    req_op = op;
    req_addr = addr;
    req_valid = 1'b1;
    while (!req_ready && guard < 300) begin
      step();
      guard++;
    end
    check("push_ready", {31'd0, req_ready}, 32'd1);
    pc = cyc;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n, input int budget);
    int k = 0;
    while (rsp_log.size() < n && k < budget) begin
      step();
      k++;
    end
    check("rsp_count", rsp_log.size(), n);
  endtask

  initial begin
    vec_t          vec [6];
    rsp_t          r;
    int            pc, n0, a0, b0;
    logic [AW-1:0] exp_addr [5];
    logic [1:0]    exp_op [5];
    logic [31:0]   tmp;
    logic [1:0]    rop;
    logic          rhit, rhitm;

    vec[0] = '{2'd0, 32'h0000_1040, 1'b0, 1'b0, 2'd2, 14, 11};
    vec[1] = '{2'd1, 32'h0000_1080, 1'b1, 1'b0, 2'd0, 14, 11};
    vec[2] = '{2'd2, 32'h0000_2000, 1'b1, 1'b0, 2'd0,  6,  3};
    vec[3] = '{2'd3, 32'h0000_30C0, 1'b1, 1'b1, 2'd1, 14, 11};
    vec[4] = '{2'd0, 32'hFFFF_FFC0, 1'b0, 1'b1, 2'd1, 14, 11};
    vec[5] = '{2'd2, 32'h8000_0040, 1'b0, 1'b0, 2'd2,  6,  3};

    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'd0; req_addr = '0;
    bus_gnt = 1'b1; bus_hit = 1'b0; bus_hitm = 1'b0; bus_beat_ack = 1'b1;
    step(); step();
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_bus_busy", {31'd0, bus_busy}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_addr_valid", {31'd0, bus_addr_valid}, 32'd0);
    check("rst_rsp_addr", rsp_addr, 32'd0);
    rst_n = 1'b1;
    step();

    // Directed vectors: immediate grant, ack every cycle.
    for (int v = 0; v < 6; v++) begin
      bus_hit = vec[v].hit;
      bus_hitm = vec[v].hitm;
      n0 = rsp_log.size(); a0 = av_total; b0 = busy_total;
      push(vec[v].op, vec[v].addr, pc);
      wait_rsp(n0 + 1, 60);
      r = rsp_log[n0];
      check($sformatf("v%0d_rsp_op", v), {30'd0, r.op}, {30'd0, vec[v].op});
      check($sformatf("v%0d_rsp_addr", v), r.addr, vec[v].addr);
      check($sformatf("v%0d_rsp_snoop", v), {30'd0, r.snoop}, {30'd0, vec[v].snoop});
      check($sformatf("v%0d_latency", v), r.cyc - pc, vec[v].lat);
      check($sformatf("v%0d_addr_pulses", v), av_total - a0, 32'd1);
      check($sformatf("v%0d_bus_addr", v), av_addr, vec[v].addr);
      check($sformatf("v%0d_bus_op", v), {30'd0, av_op}, {30'd0, vec[v].op});
      check($sformatf("v%0d_busy_cycles", v), busy_total - b0, vec[v].busy);
      step();
    end
    bus_hit = 1'b0; bus_hitm = 1'b0;
    step(); step();
    check("rsp_hold_valid", {31'd0, rsp_valid}, 32'd0);
    check("rsp_hold_addr", rsp_addr, vec[5].addr);

    // Backpressure: four pushes fill the queue without a grant; the fifth waits.
    bus_gnt = 1'b0;
    n0 = rsp_log.size(); a0 = av_total;
    for (int i = 0; i < 5; i++) begin
      exp_addr[i] = 32'h0001_0000 + 32'(i) * 32'h40;
      exp_op[i] = 2'(i);
    end
    for (int i = 0; i < 4; i++) push(exp_op[i], exp_addr[i], pc);
    check("full_ready", {31'd0, req_ready}, 32'd0);
    req_op = exp_op[4]; req_addr = exp_addr[4]; req_valid = 1'b1;
    step(); step(); step();
    check("full_held_ready", {31'd0, req_ready}, 32'd0);
    check("no_addr_without_gnt", av_total - a0, 32'd0);
    check("arb_bus_req", {31'd0, bus_req}, 32'd1);
    bus_gnt = 1'b1;
    push(exp_op[4], exp_addr[4], pc);
    wait_rsp(n0 + 5, 400);
    for (int i = 0; i < 5; i++) begin
      r = rsp_log[n0 + i];
      check($sformatf("order%0d_addr", i), r.addr, exp_addr[i]);
      check($sformatf("order%0d_op", i), {30'd0, r.op}, {30'd0, exp_op[i]});
    end
    step();

    // Slow acks: every third DATA cycle carries a beat.
    ack_mode = 1;
    n0 = rsp_log.size(); b0 = busy_total;
    push(2'd0, 32'h0000_5000, pc);
    wait_rsp(n0 + 1, 100);
    r = rsp_log[n0];
    check("slow_latency", r.cyc - pc, 32'd30);
    check("slow_busy_cycles", busy_total - b0, 32'd27);
    check("slow_snoop", {30'd0, r.snoop}, 32'd2);
    step();

    // Reset while stalled in DATA with two entries queued.
    ack_mode = 3;
    n0 = rsp_log.size();
    push(2'd0, 32'h0000_6000, pc);
    push(2'd3, 32'h0000_6040, pc);
    for (int i = 0; i < 10; i++) step();
    check("stall_busy", {31'd0, bus_busy}, 32'd1);
    a0 = av_total;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_bus_req", {31'd0, bus_req}, 32'd0);
    check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_bus_busy", {31'd0, bus_busy}, 32'd0);
    ack_mode = 0;
    for (int i = 0; i < 40; i++) step();
    check("midrst_no_rsp", rsp_log.size(), n0);
    check("midrst_no_addr", av_total - a0, 32'd0);

    // Randomized transactions with random grant and ack behaviour.
    ack_mode = 2;
    gnt_rand = 1'b1;
    for (int t = 0; t < 30; t++) begin
      tmp = $urandom();
      rop = 2'($urandom_range(0, 3));
      rhit = 1'($urandom_range(0, 1));
      rhitm = 1'($urandom_range(0, 1));
      bus_hit = rhit;
      bus_hitm = rhitm;
      n0 = rsp_log.size(); a0 = av_total;
      push(rop, tmp & 32'hFFFF_FFC0, pc);
      wait_rsp(n0 + 1, 400);
      r = rsp_log[n0];
      check($sformatf("rnd%0d_op", t), {30'd0, r.op}, {30'd0, rop});
      check($sformatf("rnd%0d_addr", t), r.addr, tmp & 32'hFFFF_FFC0);
      check($sformatf("rnd%0d_snoop", t), {30'd0, r.snoop}, {30'd0, model_snoop(rhit, rhitm)});
      check($sformatf("rnd%0d_addr_pulses", t), av_total - a0, 32'd1);
      check($sformatf("rnd%0d_min_latency", t),
            {31'd0, (r.cyc - pc) >= ((rop == 2'd2) ? 6 : 14)}, 32'd1);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
    end
    gnt_rand = 1'b0;
    bus_gnt = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
